// File: rtl/axi_signal_writer_pkg.sv
// Shared types for axi_signal_writer: FSM state encoding and FIFO pointer sizing.
// The READ/READ_RESP states exist only when AXI_SIGNAL_WRITER_READBACK_EN is defined.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef RESP_OKAY
`define RESP_OKAY 2'b00
`endif

package axi_signal_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRITE_RESP
`ifdef AXI_SIGNAL_WRITER_READBACK_EN
        ,
        ST_READ,
        ST_READ_RESP
`endif
    } state_t;

    // One extra MSB so full and empty are distinguishable with equal indices.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEPTH_DEFAULT = 4;
    localparam int FIFO_PTR_W    = fifo_ptr_w(DEPTH_DEFAULT);

endpackage

// File: rtl/axi_signal_writer_if.sv
// AXI-lite bus bundle with master and slave views.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

interface if_axi_light;
    logic [31:0]                     awaddr;
    logic [2:0]                      awprot;
    logic                            awvalid;
    logic                            awready;
    logic [`AXI_DATA_WIDTH-1:0]      wdata;
    logic [`AXI_DATA_WIDTH/8-1:0]    wstrb;
    logic                            wvalid;
    logic                            wready;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [31:0]                     araddr;
    logic [2:0]                      arprot;
    logic                            arvalid;
    logic                            arready;
    logic [`AXI_DATA_WIDTH-1:0]      rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_signal_writer_fifo.sv
// sync_fifo_sc: single-clock FIFO with full/empty flags and synchronous active-high reset.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo_sc
    import axi_signal_writer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_res,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = fifo_ptr_w(DEPTH);
    localparam int IW = PW - 1;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                       (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[IW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[IW-1:0]] <= i_data;
    end
endmodule

// File: rtl/axi_signal_writer.sv
// Turns local strobe+data pushes into AXI-lite writes to a fixed address, one per FIFO entry.
// AXI_SIGNAL_WRITER_READBACK_EN adds a read-back of each written word and an o_mismatch pulse.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef RESP_OKAY
`define RESP_OKAY 2'b00
`endif

// state         | meaning
// ST_IDLE       | waiting for a queued word; pops head and raises awvalid/wvalid
// ST_WRITE      | address and data channels handshaking independently
// ST_WRITE_RESP | bready high, waiting for bvalid
// ST_READ       | (readback) arvalid high, waiting for arready
// ST_READ_RESP  | (readback) rready high, waiting for rvalid; compares rdata
module axi_signal_writer
    import axi_signal_writer_pkg::*;
#(
    parameter logic [31:0] ADDR_TARGET = 32'h00FF_FFFC,
    parameter int          DEPTH       = 4,
    parameter logic [2:0]  PROT        = 3'b000
) (
    input  logic                       i_clk,
    input  logic                       i_res,
    input  logic                       i_sig,
    input  logic [`AXI_DATA_WIDTH-1:0] i_data,
    output logic                       o_busy,
    output logic                       o_overflow,
    output logic                       o_err,
    if_axi_light.master                m_axi
`ifdef AXI_SIGNAL_WRITER_READBACK_EN
    ,
    output logic                       o_mismatch
`endif
);
    state_t                     r_state;
    logic [`AXI_DATA_WIDTH-1:0] r_word;
    logic                       r_awvalid;
    logic                       r_wvalid;
    logic                       r_bready;
    logic                       r_err;
    logic                       r_overflow;

    logic [`AXI_DATA_WIDTH-1:0] w_head;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_pop;
    logic                       w_drop;
    logic                       w_aw_done;
    logic                       w_w_done;

    assign w_pop     = (r_state == ST_IDLE) & ~w_empty;
    assign w_drop    = i_sig & w_full & ~w_pop;
    assign w_aw_done = ~r_awvalid | m_axi.awready;
    assign w_w_done  = ~r_wvalid | m_axi.wready;

    sync_fifo_sc #(
        .WIDTH (`AXI_DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_res   (i_res),
        .i_push  (i_sig),
        .i_data  (i_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign m_axi.awaddr  = ADDR_TARGET;
    assign m_axi.awprot  = PROT;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.wdata   = r_word;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = r_wvalid;
    assign m_axi.bready  = r_bready;
    assign m_axi.araddr  = ADDR_TARGET;
    assign m_axi.arprot  = PROT;

    assign o_busy     = ~w_empty | (r_state != ST_IDLE);
    assign o_overflow = r_overflow;
    assign o_err      = r_err;

`ifdef AXI_SIGNAL_WRITER_READBACK_EN
    logic r_arvalid;
    logic r_rready;
    logic r_mismatch;

    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = r_rready;
    assign o_mismatch    = r_mismatch;
`else
    logic w_unused_rd;

    assign m_axi.arvalid = 1'b0;
    assign m_axi.rready  = 1'b0;
    assign w_unused_rd   = ^{m_axi.arready, m_axi.rvalid, m_axi.rdata, m_axi.rresp};
`endif

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state    <= ST_IDLE;
            r_word     <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_err      <= 1'b0;
            r_overflow <= 1'b0;
`ifdef AXI_SIGNAL_WRITER_READBACK_EN
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_mismatch <= 1'b0;
`endif
        end else begin
            r_err <= 1'b0;
`ifdef AXI_SIGNAL_WRITER_READBACK_EN
            r_mismatch <= 1'b0;
`endif
            if (w_drop) r_overflow <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_word    <= w_head;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (r_awvalid && m_axi.awready) r_awvalid <= 1'b0;
                    if (r_wvalid && m_axi.wready)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WRITE_RESP;
                    end
                end
                ST_WRITE_RESP: begin
                    if (m_axi.bvalid) begin
                        r_bready <= 1'b0;
                        r_err    <= (m_axi.bresp != `RESP_OKAY);
`ifdef AXI_SIGNAL_WRITER_READBACK_EN
                        r_arvalid <= 1'b1;
                        r_state   <= ST_READ;
`else
                        r_state   <= ST_IDLE;
`endif
                    end
                end
`ifdef AXI_SIGNAL_WRITER_READBACK_EN
                ST_READ: begin
                    if (m_axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_READ_RESP;
                    end
                end
                ST_READ_RESP: begin
                    if (m_axi.rvalid) begin
                        r_rready   <= 1'b0;
                        r_mismatch <= (m_axi.rdata != r_word);
                        r_err      <= (m_axi.rresp != `RESP_OKAY);
                        r_state    <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
